// File: rtl/veda_fp_writeback.sv
// veda_fp_writeback: fetches two single-precision operands from a VEDA memory
// port, hands them to an external combinational fp_adder and writes the sum
// back to a third VEDA address. One operation takes seven cycles.
module veda_fp_writeback #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_r,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              mem_mode,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    input  logic [DATA_W-1:0] add_sum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CAP_B,
        S_ADD,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_lat_a;
    logic [ADDR_W-1:0] r_lat_b;
    logic [ADDR_W-1:0] r_lat_r;
    logic [DATA_W-1:0] r_sum;

    // Sequencer: every output is loaded on the edge that enters the state it
    // belongs to, so each output is a pure register with no path from start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_lat_a   <= '0;
            r_lat_b   <= '0;
            r_lat_r   <= '0;
            r_sum     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            mem_mode  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            add_a     <= '0;
            add_b     <= '0;
        end else begin
            // NOTE: non-blocking everywhere here; the pulse defaults below are
            // overridden by the one state that raises them, without ordering races.
            done   <= 1'b0;
            mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_lat_a  <= addr_a;
                        r_lat_b  <= addr_b;
                        r_lat_r  <= addr_r;
                        busy     <= 1'b1;
                        mem_mode <= 1'b1;
                        mem_addr <= addr_a;
                        r_state  <= S_RD_A;
                    end
                end
                S_RD_A: begin
                    mem_addr <= r_lat_b;
                    r_state  <= S_RD_B;
                end
                S_RD_B: begin
                    // Read data for A arrives one cycle after its address.
                    add_a   <= mem_rdata;
                    r_state <= S_CAP_B;
                end
                S_CAP_B: begin
                    add_b   <= mem_rdata;
                    r_state <= S_ADD;
                end
                S_ADD: begin
                    // Sum is taken verbatim; special encodings pass untouched.
                    r_sum     <= add_sum;
                    mem_wdata <= add_sum;
                    mem_mode  <= 1'b0;
                    mem_we    <= 1'b1;
                    mem_addr  <= r_lat_r;
                    r_state   <= S_WRITE;
                end
                S_WRITE: begin
                    done     <= 1'b1;
                    result   <= r_sum;
                    mem_mode <= 1'b1;
                    mem_addr <= '0;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    mem_mode <= 1'b1;
                    mem_addr <= '0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/veda_fp_writeback.md
Name: veda_fp_writeback

Overview:
- Sequential controller that drives a VEDA memory port in both directions.
- Fetches two IEEE-754 single-precision operands from VEDA and presents them to an external combinational fp_adder.
- Writes the sum back into VEDA at a third address.
- It is the writer/producer end of the VEDA interface. It fills the result locations that the VEDA checker logic later reads back and compares against.

Parameters:
- ADDR_W, 5, VEDA address width.
- DATA_W, 32, word width (IEEE-754 single).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse, sampled only in IDLE
- addr_a  input  ADDR_W  address of operand A
- addr_b  input  ADDR_W  address of operand B
- addr_r  input  ADDR_W  address where the sum is written
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse when the write has completed
- result  output  DATA_W  last sum written; holds until the next DONE
- mem_mode  output  1  VEDA mode: 1 = read, 0 = write
- mem_we  output  1  VEDA write_enable
- mem_addr  output  ADDR_W  VEDA address
- mem_wdata  output  DATA_W  VEDA data_in
- mem_rdata  input  DATA_W  VEDA data_out; valid 1 cycle after the address is presented in read mode
- add_a  output  DATA_W  operand A to fp_adder (registered)
- add_b  output  DATA_W  operand B to fp_adder (registered)
- add_sum  input  DATA_W  fp_adder result, combinational from add_a/add_b

Behaviour:
- One clock domain.
- Reset is synchronous and active-high: `reset` is sampled on the rising edge of `clk`.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, result = 0
  - mem_mode = 1, mem_we = 0, mem_addr = 0, mem_wdata = 0
  - add_a = 0, add_b = 0
  - latched addresses = 0
- States and transitions (one state per cycle unless noted):
  - IDLE: mem_mode = 1, mem_we = 0, mem_addr = 0. If start = 1, latch addr_a/addr_b/addr_r and go to RD_A; otherwise stay in IDLE.
  - RD_A: mem_addr = latched A, mem_mode = 1 -> RD_B.
  - RD_B: mem_addr = latched B, mem_mode = 1; capture mem_rdata into add_a -> CAP_B.
  - CAP_B: mem_mode = 1; capture mem_rdata into add_b -> ADD.
  - ADD: capture add_sum into the sum register -> WRITE.
  - WRITE: mem_mode = 0, mem_we = 1, mem_addr = latched R, mem_wdata = sum register -> DONE.
  - DONE: done = 1, result = sum register, mem_we = 0 -> IDLE.
- mem_we is high in exactly one cycle per operation (the WRITE state). It is never high in any other state.
- Latency: start sampled in IDLE at edge t; done is high during cycle t+6. Back-to-back throughput is one operation per 7 cycles.
- start while busy = 1 is ignored. It is not queued and the latched addresses do not change.
- Address aliasing: addr_r equal to addr_a or addr_b is legal. Both reads complete before the write, so the operands are the pre-write values. addr_a == addr_b is legal and yields A+A.
- Reset mid-operation: the next state is IDLE and busy drops. If reset is asserted during the WRITE cycle, mem_we is 0 from the following cycle. No done pulse is produced for the aborted operation, and result returns to 0.
- No arithmetic is done in this block. The sum is taken verbatim from add_sum, including NaN, Inf and denormal encodings.
- Outputs are decoded from state and registers only. There is no combinational path from start to the mem_* outputs.

Test Plan:
- Nominal add: M[2] = 32'h42BA8000 (93.25), M[3] = 32'h414D0000 (12.8125), start with a=2, b=3, r=4 -> M[4] = 32'h42D42000 (106.0625). done pulses exactly at start+6, result = 32'h42D42000, and there is exactly one mem_we cycle.
- Aliased destination: M[5] = 32'h3F800000, M[6] = 32'h40000000, a=5, b=6, r=5 -> M[5] = 32'h40400000. The operand read into add_a is 32'h3F800000.
- Same operand: M[1] = 32'h40000000, a=b=1, r=7 -> M[7] = 32'h40800000.
- Ignored start: issue start again at start+2 with r=9 -> only one done pulse, and M[9] is unchanged.
- Reset mid-operation: assert reset for 1 cycle while in CAP_B -> next cycle busy=0, mem_we=0, result=0, no done pulse, and M[r] is unchanged. A subsequent start completes normally.
- Back-to-back: raise start again on the cycle after done -> the second operation's done arrives 7 cycles after the first, and both results are correct in memory.
